// File: rtl/mc_ctrl_fsm_if.sv
// Instruction/data memory handshake bundle for the multi-cycle control sequencer.
interface mc_ctrl_fsm_if;
  logic [31:0] inst;
  logic        imem_valid;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  inst, imem_valid, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output inst, imem_valid, dmem_ack
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode, execute, variable-latency memory access, sticky trap.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_fsm_if.master    bus,
  output logic             pc_en,
  output logic             reg_write,
  output logic             result_src,
  output logic             alu_src,
  output logic             link,
  output logic [1:0]       pc_src,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_op,
  output logic             sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             fault,
  output logic [1:0]       fault_code
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;
  typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR} cls_t;

  state_t          state, next;
  cls_t            cls_q, dec_cls;
  logic            dec_legal;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_inst_bits;

  assign opcode           = bus.inst[6:0];
  assign funct3           = bus.inst[14:12];
  assign funct7           = bus.inst[31:25];
  assign unused_inst_bits = ^{bus.inst[24:15], bus.inst[11:7]};
  assign timeout          = (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  // Decode the live instruction into a legality flag and an operation class.
  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = C_NONE;
    case (opcode)
      7'b0110011: begin
        dec_legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        dec_cls   = C_R;
      end
      7'b0010011: begin
        if (funct3 == 3'b001)      dec_legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       dec_legal = 1'b1;
        dec_cls = C_I;
      end
      7'b0000011: begin dec_legal = (funct3 == 3'b010); dec_cls = C_LOAD;  end
      7'b0100011: begin dec_legal = (funct3 == 3'b010); dec_cls = C_STORE; end
      7'b1100011: begin
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec_cls   = C_BRANCH;
      end
      7'b1101111: begin dec_legal = 1'b1;               dec_cls = C_JAL;  end
      7'b1100111: begin dec_legal = (funct3 == 3'b000); dec_cls = C_JALR; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next;
  end

  // Next-state selection; ack wins over timeout in the same MEM cycle.
  always_comb begin
    next = state;
    case (state)
      S_FETCH: if (bus.imem_valid) next = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC:  next = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_FETCH;
      S_MEM:   if (bus.dmem_ack) next = S_FETCH;
               else if (timeout) next = S_TRAP;
      S_TRAP:  next = S_TRAP;
      default: next = S_FETCH;
    endcase
  end

  // Class latch, memory timeout counter, retire counter and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q      <= C_NONE;
      to_cnt     <= '0;
      instret    <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      if (state == S_FETCH && bus.imem_valid) begin
        if (dec_legal) begin
          cls_q <= dec_cls;
        end else begin
          fault      <= 1'b1;
          fault_code <= 2'b01;
        end
      end
      if (state == S_EXEC) to_cnt <= '0;
      if (state == S_MEM && !bus.dmem_ack) begin
        to_cnt <= to_cnt + 1'b1;
        if (timeout) begin
          fault      <= 1'b1;
          fault_code <= 2'b10;
        end
      end
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Controls from the latched class plus live inst fields; strobes per state, all killed by rst.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    pc_en        = 1'b0;
    reg_write    = 1'b0;
    retire       = 1'b0;
    result_src   = 1'b0;
    alu_src      = 1'b0;
    link         = 1'b0;
    pc_src       = 2'b00;
    imm_src      = 2'b00;
    alu_op       = 3'b000;
    sel          = 1'b0;
    if (state == S_EXEC || state == S_MEM) begin
      case (cls_q)
        C_R:      begin alu_op = funct3; sel = bus.inst[30]; end
        C_I:      begin
          alu_src = 1'b1;
          alu_op  = funct3;
          sel     = (funct3 == 3'b101) && bus.inst[30];
        end
        C_LOAD:   begin alu_src = 1'b1; result_src = 1'b1; end
        C_STORE:  begin alu_src = 1'b1; imm_src = 2'b01; end
        C_BRANCH: begin imm_src = 2'b10; sel = 1'b1; pc_src = 2'b11; end
        C_JAL:    begin imm_src = 2'b11; pc_src = 2'b01; link = 1'b1; end
        C_JALR:   begin alu_src = 1'b1; pc_src = 2'b10; link = 1'b1; end
        default: ;
      endcase
    end
    case (state)
      S_FETCH: bus.imem_req = 1'b1;
      S_EXEC: if (cls_q != C_LOAD && cls_q != C_STORE) begin
        pc_en     = 1'b1;
        retire    = 1'b1;
        reg_write = (cls_q == C_R) || (cls_q == C_I) || (cls_q == C_JAL) || (cls_q == C_JALR);
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (cls_q == C_STORE);
        if (bus.dmem_ack) begin
          pc_en     = 1'b1;
          retire    = 1'b1;
          reg_write = (cls_q == C_LOAD);
        end
      end
      default: ;
    endcase
    if (rst) begin
      pc_en        = 1'b0;
      reg_write    = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      retire       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm: decode table plus multi-cycle memory, timeout and reset sequences.
module tb_mc_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en, reg_write, result_src, alu_src, link, sel, retire, fault;
  logic [1:0]  pc_src, imm_src, fault_code;
  logic [2:0]  alu_op;
  logic [31:0] instret;
  logic [11:0] ctrl_obs;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pc_en(pc_en), .reg_write(reg_write), .result_src(result_src), .alu_src(alu_src),
    .link(link), .pc_src(pc_src), .imm_src(imm_src), .alu_op(alu_op), .sel(sel),
    .retire(retire), .instret(instret), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {reg_write, alu_src, imm_src, alu_op, sel, pc_src, link, result_src};

  int checks = 0;
  int errors = 0;
  int unsigned exp_ret = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [1:0]  kind;   // 0 alu/branch/jump, 1 load, 2 store, 3 illegal
    logic [11:0] ctrl;   // {reg_write, alu_src, imm_src, alu_op, sel, pc_src, link, result_src} in EXEC
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_ret = 0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add",   32'h002081B3, 2'd0, 12'b1_0_00_000_0_00_0_0};
    vecs[1]  = '{"sub",   32'h402081B3, 2'd0, 12'b1_0_00_000_1_00_0_0};
    vecs[2]  = '{"sra",   32'h4020D1B3, 2'd0, 12'b1_0_00_101_1_00_0_0};
    vecs[3]  = '{"andi",  32'hFFF0F093, 2'd0, 12'b1_1_00_111_0_00_0_0};
    vecs[4]  = '{"srai",  32'h4030D093, 2'd0, 12'b1_1_00_101_1_00_0_0};
    vecs[5]  = '{"beq",   32'h00208463, 2'd0, 12'b0_0_10_000_1_11_0_0};
    vecs[6]  = '{"jal",   32'h008000EF, 2'd0, 12'b1_0_11_000_0_01_1_0};
    vecs[7]  = '{"jalr",  32'h000100E7, 2'd0, 12'b1_1_00_000_0_10_1_0};
    vecs[8]  = '{"lw",    32'h0080A283, 2'd1, 12'b0_1_00_000_0_00_0_1};
    vecs[9]  = '{"sw",    32'h0050A423, 2'd2, 12'b0_1_01_000_0_00_0_0};
    vecs[10] = '{"ones",  32'hFFFFFFFF, 2'd3, 12'b0};
    vecs[11] = '{"slli7", 32'h40209093, 2'd3, 12'b0};
    vecs[12] = '{"and7",  32'h4020F1B3, 2'd3, 12'b0};
    vecs[13] = '{"lb",    32'h00008283, 2'd3, 12'b0};
    vecs[14] = '{"bge",   32'h0020D463, 2'd3, 12'b0};

    rst = 1'b1;
    bus.inst = 32'h0;
    bus.imem_valid = 1'b0;
    bus.dmem_ack = 1'b0;
    do_reset();

    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd1);
    chk("rst_instret", instret, 32'd0);
    chk("rst_fault", {29'b0, fault, fault_code}, 32'd0);
    chk("rst_ctrl", {20'b0, ctrl_obs}, 32'd0);
    chk("rst_strobes", {27'b0, pc_en, retire, bus.dmem_req, bus.dmem_we, reg_write}, 32'd0);

    foreach (vecs[i]) begin
      bus.inst = vecs[i].inst;
      bus.imem_valid = 1'b1;
      #1;
      chk({vecs[i].name, "_fetch_strobes"}, {30'b0, pc_en, reg_write}, 32'd0);
      step();
      bus.imem_valid = 1'b0;
      #1;
      if (vecs[i].kind == 2'd3) begin
        chk({vecs[i].name, "_trap"}, {28'b0, bus.imem_req, fault, fault_code}, 32'b0_1_01);
        chk({vecs[i].name, "_trap_pc_en"}, {31'b0, pc_en}, 32'd0);
        do_reset();
        chk({vecs[i].name, "_cleared"}, {28'b0, bus.imem_req, fault, fault_code}, 32'b1_0_00);
      end else begin
        chk({vecs[i].name, "_ctrl"}, {20'b0, ctrl_obs}, {20'b0, vecs[i].ctrl});
        if (vecs[i].kind == 2'd0) begin
          chk({vecs[i].name, "_exec_strb"}, {29'b0, pc_en, retire, bus.dmem_req}, 32'b110);
          exp_ret++;
          step();
        end else begin
          chk({vecs[i].name, "_exec_strb"}, {29'b0, pc_en, retire, bus.dmem_req}, 32'b000);
          step();
          bus.dmem_ack = 1'b1;
          #1;
          chk({vecs[i].name, "_mem_ack"}, {27'b0, bus.dmem_req, bus.dmem_we, pc_en, retire, reg_write},
              {27'b0, 1'b1, vecs[i].kind == 2'd2, 1'b1, 1'b1, vecs[i].kind == 2'd1});
          chk({vecs[i].name, "_mem_ctrl"}, {20'b0, ctrl_obs},
              {20'b0, vecs[i].kind == 2'd1, vecs[i].ctrl[10:0]});
          exp_ret++;
          step();
          bus.dmem_ack = 1'b0;
        end
        chk({vecs[i].name, "_instret"}, instret, exp_ret);
        chk({vecs[i].name, "_refetch"}, {31'b0, bus.imem_req}, 32'd1);
      end
    end

    // lw with ack in the third MEM cycle
    bus.inst = 32'h0080A283;
    bus.imem_valid = 1'b1;
    step();
    bus.imem_valid = 1'b0;
    step();
    for (int c = 0; c < 2; c++) begin
      chk("lw3_wait", {27'b0, bus.dmem_req, bus.dmem_we, pc_en, reg_write, result_src}, 32'b10001);
      step();
    end
    bus.dmem_ack = 1'b1;
    #1;
    chk("lw3_ack", {27'b0, bus.dmem_req, bus.dmem_we, pc_en, reg_write, retire}, 32'b10111);
    step();
    bus.dmem_ack = 1'b0;
    exp_ret++;
    chk("lw3_instret", instret, exp_ret);

    // back-to-back adds with imem_valid held high: 2 cycles each
    bus.inst = 32'h002081B3;
    bus.imem_valid = 1'b1;
    for (int c = 0; c < 4; c++) step();
    bus.imem_valid = 1'b0;
    exp_ret += 2;
    chk("b2b_instret", instret, exp_ret);

    // sw acked in the last allowed MEM cycle still retires
    bus.inst = 32'h0050A423;
    bus.imem_valid = 1'b1;
    step();
    bus.imem_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    bus.dmem_ack = 1'b1;
    #1;
    chk("sw_late_ack", {28'b0, bus.dmem_we, pc_en, retire, fault}, 32'b1110);
    step();
    bus.dmem_ack = 1'b0;
    exp_ret++;
    chk("sw_late_instret", instret, exp_ret);

    // sw with no ack: trap after 4 MEM cycles
    bus.inst = 32'h0050A423;
    bus.imem_valid = 1'b1;
    step();
    bus.imem_valid = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("sw_to_wait", {28'b0, bus.dmem_req, bus.dmem_we, pc_en, fault}, 32'b1100);
      step();
    end
    chk("sw_to_trap", {27'b0, bus.imem_req, bus.dmem_req, fault, fault_code}, 32'b0_0_1_10);
    chk("sw_to_instret", instret, exp_ret);
    bus.dmem_ack = 1'b1;
    bus.imem_valid = 1'b1;
    for (int c = 0; c < 3; c++) step();
    bus.dmem_ack = 1'b0;
    bus.imem_valid = 1'b0;
    chk("trap_sticky", {27'b0, bus.imem_req, pc_en, fault, fault_code}, 32'b0_0_1_10);
    chk("trap_instret", instret, exp_ret);
    do_reset();

    // reset asserted for 2 cycles in MEM while dmem_ack is high
    bus.inst = 32'h0080A283;
    bus.imem_valid = 1'b1;
    step();
    bus.imem_valid = 1'b0;
    step();
    rst = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    chk("rst_mem_strb0", {27'b0, pc_en, reg_write, bus.dmem_req, bus.dmem_we, retire}, 32'd0);
    step();
    chk("rst_mem_strb1", {27'b0, pc_en, reg_write, bus.dmem_req, bus.dmem_we, retire}, 32'd0);
    step();
    rst = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    chk("rst_mem_after", {28'b0, bus.imem_req, fault, fault_code}, 32'b1_0_00);
    chk("rst_mem_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
